// File: rtl/datapath_ctrl_pkg.sv
// Shared types and instruction field helpers for the register-file/ALU sequencer.
// Field positions are derived from INSTR_W and SEL_W so every width variant decodes identically.
package datapath_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_ALU  = 2'b00,
        OP_MOV  = 2'b01,
        OP_ILL2 = 2'b10,
        OP_ILL3 = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_WRITE  = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    localparam int OP_LSB   = 0;
    localparam int MODE_BIT = 2;
    localparam int ALU_LSB  = 3;

    function automatic int rx_msb(input int instr_w);
        return instr_w - 1;
    endfunction

    function automatic int ry_msb(input int instr_w, input int sel_w);
        return instr_w - 1 - sel_w;
    endfunction

    function automatic int min_instr_w(input int sel_w, input int alu_sel_w);
        return 2 * sel_w + alu_sel_w + 3;
    endfunction

    function automatic logic is_illegal(input op_t op);
        return (op == OP_ILL2) || (op == OP_ILL3);
    endfunction

    // First state after an instruction is accepted, from IDLE or (autorun) from FIN.
    function automatic state_t entry_state(input op_t op);
        case (op)
            OP_ALU:  return ST_LOAD_A;
            OP_MOV:  return ST_WRITE;
            default: return ST_FIN;
        endcase
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary-to-one-hot decoder with enable; drives the register-file write enables.
module onehot_dec #(
    parameter int SEL_W    = 3,
    parameter int NUM_REGS = 8
) (
    input  logic                en,
    input  logic [SEL_W-1:0]    idx,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/datapath_seq_ctrl.sv
// Multi-cycle sequencer: operand loads into S/C, ALU op, one-hot register write-back.
// Define DATAPATH_SEQ_CTRL_AUTORUN_EN to let FIN accept the next instruction directly.
module datapath_seq_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int  NUM_REGS  = 8,
    parameter int  ALU_SEL_W = 4,
    parameter int  INSTR_W   = 16,
    localparam int SEL_W     = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [INSTR_W-1:0]   instruction,
    input  logic                 run,
    output logic [SEL_W:0]       mux_sel,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 mode,
    output logic                 en_s,
    output logic                 en_c,
    output logic [NUM_REGS-1:0]  reg_en,
    output logic                 en_inst,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int             RX_MSB  = rx_msb(INSTR_W);
    localparam int             RY_MSB  = ry_msb(INSTR_W, SEL_W);
    localparam logic [SEL_W:0] MUX_ALU = (SEL_W + 1)'(NUM_REGS);

    if (INSTR_W < min_instr_w(SEL_W, ALU_SEL_W)) begin : g_bad_instr_w
        $error("datapath_seq_ctrl: INSTR_W too narrow for rx/ry/alu_sel/mode/op fields");
    end
    if ((NUM_REGS < 2) || (NUM_REGS > 16) || ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : g_bad_num_regs
        $error("datapath_seq_ctrl: NUM_REGS must be a power of two in 2..16");
    end

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q;
    logic                 latch;
    logic                 wr_en;
    logic                 en_inst_c;
    logic [SEL_W-1:0]     rx_f, ry_f;
    logic [ALU_SEL_W-1:0] alu_f;
    logic                 mode_f;
    op_t                  op_q, op_in;
    logic                 unused_instr;

    assign rx_f         = instr_q[RX_MSB -: SEL_W];
    assign ry_f         = instr_q[RY_MSB -: SEL_W];
    assign alu_f        = instr_q[ALU_LSB +: ALU_SEL_W];
    assign mode_f       = instr_q[MODE_BIT];
    assign op_q         = op_t'(instr_q[OP_LSB +: 2]);
    assign op_in        = op_t'(instruction[OP_LSB +: 2]);
    assign unused_instr = ^instr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                instr_q <= instruction;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        latch     = 1'b0;
        wr_en     = 1'b0;
        en_inst_c = 1'b0;
        mux_sel   = '0;
        alu_sel   = '0;
        mode      = 1'b0;
        en_s      = 1'b0;
        en_c      = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy      = 1'b0;
                en_inst_c = 1'b1;
                if (run) begin
                    latch   = 1'b1;
                    state_d = entry_state(op_in);
                end
            end
            ST_LOAD_A: begin
                mux_sel = {1'b0, rx_f};
                en_s    = 1'b1;
                state_d = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                mux_sel = {1'b0, ry_f};
                en_c    = 1'b1;
                alu_sel = alu_f;
                mode    = mode_f;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wr_en = 1'b1;
                if (op_q == OP_ALU) begin
                    mux_sel = MUX_ALU;
                    alu_sel = alu_f;
                    mode    = mode_f;
                end else begin
                    mux_sel = {1'b0, ry_f};
                end
                state_d = ST_FIN;
            end
            ST_FIN: begin
                done    = 1'b1;
                err     = is_illegal(op_q);
                state_d = ST_IDLE;
`ifdef DATAPATH_SEQ_CTRL_AUTORUN_EN
                if (run) begin
                    en_inst_c = 1'b1;
                    latch     = 1'b1;
                    state_d   = entry_state(op_in);
                end
`endif
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset parks the FSM in IDLE, whose en_inst strobe must still read 0 while reset is held.
    assign en_inst = en_inst_c & reset_n;

    onehot_dec #(
        .SEL_W    (SEL_W),
        .NUM_REGS (NUM_REGS)
    ) u_reg_dec (
        .en     (wr_en),
        .idx    (rx_f),
        .onehot (reg_en)
    );

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Self-checking bench for datapath_seq_ctrl: 8-register and 16-register instances,
// randomized instructions checked cycle by cycle against a schedule built from the instruction fields.
module tb_datapath_seq_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [15:0] instruction;
    logic        run;
    logic [3:0]  mux_sel;
    logic [3:0]  alu_sel;
    logic        mode, en_s, en_c, en_inst, busy, done, err;
    logic [7:0]  reg_en;

    logic [15:0] instruction16;
    logic        run16;
    logic [4:0]  mux_sel16;
    logic [3:0]  alu_sel16;
    logic        mode16, en_s16, en_c16, en_inst16, busy16, done16, err16;
    logic [15:0] reg_en16;

    int checks = 0;
    int errors = 0;
    logic [22:0] exp_q[$];
    logic [31:0] exp16_q[$];

    datapath_seq_ctrl #(.NUM_REGS(8), .ALU_SEL_W(4), .INSTR_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .instruction(instruction), .run(run),
        .mux_sel(mux_sel), .alu_sel(alu_sel), .mode(mode), .en_s(en_s), .en_c(en_c),
        .reg_en(reg_en), .en_inst(en_inst), .busy(busy), .done(done), .err(err)
    );

    datapath_seq_ctrl #(.NUM_REGS(16), .ALU_SEL_W(4), .INSTR_W(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .instruction(instruction16), .run(run16),
        .mux_sel(mux_sel16), .alu_sel(alu_sel16), .mode(mode16), .en_s(en_s16), .en_c(en_c16),
        .reg_en(reg_en16), .en_inst(en_inst16), .busy(busy16), .done(done16), .err(err16)
    );

    function automatic logic [22:0] obs8();
        return {mux_sel, alu_sel, mode, en_s, en_c, reg_en, en_inst, busy, done, err};
    endfunction

    function automatic logic [31:0] obs16();
        return {mux_sel16, alu_sel16, mode16, en_s16, en_c16, reg_en16, en_inst16, busy16, done16, err16};
    endfunction

    function automatic logic [22:0] pack8(int mx, int alu, bit md, bit es, bit ec, int re,
                                          bit ei, bit bz, bit dn, bit er);
        return {4'(mx), 4'(alu), md, es, ec, 8'(re), ei, bz, dn, er};
    endfunction

    function automatic logic [31:0] pack16(int mx, int alu, bit md, bit es, bit ec, int re,
                                           bit ei, bit bz, bit dn, bit er);
        return {5'(mx), 4'(alu), md, es, ec, 16'(re), ei, bz, dn, er};
    endfunction

    function automatic logic [22:0] idle8();
        return pack8(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endfunction

    // Reference schedule for the 8-register instance: one entry per cycle after the accept edge.
    task automatic model8(input logic [15:0] ins);
        int rx  = int'(ins[15:13]);
        int ry  = int'(ins[12:10]);
        int alu = int'(ins[6:3]);
        bit md  = ins[2];
        case (ins[1:0])
            2'b00: begin
                exp_q.push_back(pack8(rx, 0, 0, 1, 0, 0, 0, 1, 0, 0));
                exp_q.push_back(pack8(ry, alu, md, 0, 1, 0, 0, 1, 0, 0));
                exp_q.push_back(pack8(8, alu, md, 0, 0, 1 << rx, 0, 1, 0, 0));
                exp_q.push_back(pack8(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
            end
            2'b01: begin
                exp_q.push_back(pack8(ry, 0, 0, 0, 0, 1 << rx, 0, 1, 0, 0));
                exp_q.push_back(pack8(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
            end
            default: exp_q.push_back(pack8(0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        endcase
    endtask

    task automatic test_reset();
        reset_n = 1'b0; run = 1'b0; run16 = 1'b0;
        instruction = 16'hFFFF; instruction16 = 16'hFFFF;
        #1;
        checks++;
        if (obs8() !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", obs8(), 23'h0);
        end
        checks++;
        if (obs16() !== '0) begin
            errors++; $display("FAIL reset_outputs16: got %h expected %h", obs16(), 32'h0);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (obs8() !== idle8()) begin
            errors++; $display("FAIL reset_release_idle: got %h expected %h", obs8(), idle8());
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] tbl[4];
        logic [22:0] e;
        tbl[0] = {3'd3, 3'd5, 3'b000, 4'hA, 1'b1, 2'b00};
        tbl[1] = {3'd7, 3'd0, 3'b101, 4'h6, 1'b1, 2'b01};
        tbl[2] = {3'd2, 3'd4, 3'b011, 4'h3, 1'b0, 2'b11};
        tbl[3] = {3'd6, 3'd6, 3'b000, 4'hF, 1'b0, 2'b00};
        for (int t = 0; t < 4; t++) begin
            instruction = tbl[t]; run = 1'b1;
            checks++;
            if (obs8() !== idle8()) begin
                errors++; $display("FAIL directed_idle[%0d]: got %h expected %h", t, obs8(), idle8());
            end
            @(negedge clk);
            run = 1'b0;
            model8(tbl[t]);
            exp_q.push_back(idle8());
            for (int k = 0; exp_q.size() > 0; k++) begin
                e = exp_q.pop_front();
                checks++;
                if (obs8() !== e) begin
                    errors++; $display("FAIL directed[%0d] cycle T+%0d: got %h expected %h", t, k + 1, obs8(), e);
                end
                @(negedge clk);
            end
        end
    endtask

    // Instruction and run are scrambled while busy; the latched copy must still be executed once.
    task automatic test_random_ignore_busy();
        logic [15:0] ins;
        logic [22:0] e;
        for (int t = 0; t < 24; t++) begin
            ins = 16'($urandom);
            instruction = ins; run = 1'b1;
            @(negedge clk);
            model8(ins);
            exp_q.push_back(idle8());
            for (int k = 0; exp_q.size() > 0; k++) begin
                if (exp_q.size() > 2) begin
                    instruction = 16'($urandom);
                    run = 1'($urandom_range(0, 1));
                end else begin
                    run = 1'b0;
                end
                e = exp_q.pop_front();
                checks++;
                if (obs8() !== e) begin
                    errors++; $display("FAIL random[%0d] ins=%h cycle T+%0d: got %h expected %h", t, ins, k + 1, obs8(), e);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] ins;
        logic [22:0] e;
        ins = {3'd1, 3'd2, 3'b000, 4'h5, 1'b1, 2'b00};
        instruction = ins; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        e = pack8(2, 5, 1, 0, 1, 0, 0, 1, 0, 0);
        checks++;
        if (obs8() !== e) begin
            errors++; $display("FAIL midop_load_b: got %h expected %h", obs8(), e);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs8() !== '0) begin
            errors++; $display("FAIL midop_abort: got %h expected %h", obs8(), 23'h0);
        end
        @(negedge clk);
        checks++;
        if (obs8() !== '0) begin
            errors++; $display("FAIL midop_held: got %h expected %h", obs8(), 23'h0);
        end
        reset_n = 1'b1;
        ins = {3'd4, 3'd0, 3'b000, 4'h9, 1'b0, 2'b00};
        instruction = ins; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        model8(ins);
        exp_q.push_back(idle8());
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs8() !== e) begin
                errors++; $display("FAIL midop_restart cycle T+%0d: got %h expected %h", k + 1, obs8(), e);
            end
            @(negedge clk);
        end
    endtask

    // run held across two instructions; the second is presented during the first FIN.
    task automatic test_back_to_back();
        logic [15:0] ins1, ins2;
        logic [22:0] e;
        int n1;
        for (int t = 0; t < 4; t++) begin
            ins1 = 16'($urandom) & 16'hFFFC;
            ins2 = 16'($urandom);
            instruction = ins1; run = 1'b1;
            @(negedge clk);
            model8(ins1);
            n1 = exp_q.size();
`ifdef DATAPATH_SEQ_CTRL_AUTORUN_EN
            exp_q[n1 - 1] = exp_q[n1 - 1] | pack8(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
`else
            exp_q.push_back(idle8());
`endif
            model8(ins2);
            exp_q.push_back(idle8());
            for (int k = 0; exp_q.size() > 0; k++) begin
                if (k == n1 - 1) instruction = ins2;
                if (exp_q.size() <= 2) run = 1'b0;
                e = exp_q.pop_front();
                checks++;
                if (obs8() !== e) begin
                    errors++; $display("FAIL back_to_back[%0d] cycle T+%0d: got %h expected %h", t, k + 1, obs8(), e);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_wide_regs();
        logic [15:0] tbl[2];
        logic [31:0] e;
        tbl[0] = {4'd15, 4'd2, 1'b0, 4'h5, 1'b0, 2'b00};
        tbl[1] = {4'd15, 4'd15, 1'b1, 4'h7, 1'b1, 2'b01};
        for (int t = 0; t < 2; t++) begin
            instruction16 = tbl[t]; run16 = 1'b1;
            @(negedge clk);
            run16 = 1'b0;
            if (t == 0) begin
                exp16_q.push_back(pack16(15, 0, 0, 1, 0, 0, 0, 1, 0, 0));
                exp16_q.push_back(pack16(2, 5, 0, 0, 1, 0, 0, 1, 0, 0));
                exp16_q.push_back(pack16(16, 5, 0, 0, 0, 16'h8000, 0, 1, 0, 0));
            end else begin
                exp16_q.push_back(pack16(15, 0, 0, 0, 0, 16'h8000, 0, 1, 0, 0));
            end
            exp16_q.push_back(pack16(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
            exp16_q.push_back(pack16(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
            for (int k = 0; exp16_q.size() > 0; k++) begin
                e = exp16_q.pop_front();
                checks++;
                if (obs16() !== e) begin
                    errors++; $display("FAIL wide[%0d] cycle T+%0d: got %h expected %h", t, k + 1, obs16(), e);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_ignore_busy();
        test_reset_mid_op();
        test_back_to_back();
        test_wide_regs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/datapath_seq_ctrl.md
Name: datapath_seq_ctrl

Overview:
- Parametrised multi-cycle sequencer for the register-file + ALU datapath.
- Accepts one instruction per run handshake, then sequences the operand loads into the S and C staging registers, the ALU op, and the one-hot register write-back.
- Supports ALU-op and register-move instructions and flags illegal opcodes.
- Sits between the instruction register/switch front-end and the bus mux, register enables and ALU select lines.

Parameters:
- NUM_REGS, 8, number of general registers; power of two, 2..16.
- SEL_W, $clog2(NUM_REGS), register index width (derived localparam, not overridable).
- ALU_SEL_W, 4, ALU function select width.
- INSTR_W, 16, instruction width; must be >= 2*SEL_W + ALU_SEL_W + 3 (elaboration $error otherwise).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- instruction  in  INSTR_W  instruction word; fields rx=[INSTR_W-1 -: SEL_W], ry=[INSTR_W-1-SEL_W -: SEL_W], alu_sel=[ALU_SEL_W+2:3], mode=[2], op=[1:0]
- run  in  1  start request, level sampled in IDLE
- mux_sel  out  SEL_W+1  bus source: 0..NUM_REGS-1 = register, NUM_REGS = ALU result
- alu_sel  out  ALU_SEL_W  ALU function
- mode  out  1  ALU mode (logic/arith)
- en_s  out  1  load S staging register
- en_c  out  1  load C staging register
- reg_en  out  NUM_REGS  one-hot register write enable
- en_inst  out  1  instruction register load strobe
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, on illegal op

Behaviour:
- Reset (async, reset_n=0): state=IDLE; instruction latch=0; all outputs 0 (mux_sel=0, alu_sel=0, mode=0, enables 0, busy/done/err 0). Deassertion is sync'd externally.
- Reset mid-operation: abort immediately. No further enables are issued; a partial write is never completed.
- State machine (Moore): states IDLE, LOAD_A, LOAD_B, WRITE, FIN.
- Every output defaults to 0 in every state unless listed below. No latches.
- IDLE: en_inst=1.
  - run=1 latches instruction internally on that edge.
  - op=00 (ALU) -> LOAD_A; op=01 (MOV) -> WRITE; op=1x (illegal) -> FIN with err flagged.
- LOAD_A: mux_sel=rx, en_s=1 -> LOAD_B.
- LOAD_B: mux_sel=ry, en_c=1, alu_sel/mode from latched instr -> WRITE.
- WRITE:
  - ALU: mux_sel=NUM_REGS, alu_sel/mode held, reg_en[rx]=1.
  - MOV: mux_sel=ry, reg_en[rx]=1.
  - Exactly one reg_en bit is set. Next state FIN.
- FIN: done=1, err=1 if illegal -> IDLE.
- Latency from accept edge T: ALU done at T+4, MOV done at T+2, illegal done+err at T+1. Back-to-back min period = latency+1.
- Instruction input changes while busy: ignored; the latched copy is used throughout.
- run while busy: ignored, not queued.
- rx==ry: legal. ALU computes rx op rx; MOV is a self-write with reg_en[rx] pulsed.
- Unreachable state encodings -> IDLE.

Optional Feature:
- DATAPATH_SEQ_CTRL_AUTORUN_EN
- Defined: in FIN, if run=1, latch instruction, pulse en_inst alongside done, and branch directly as from IDLE. Back-to-back ALU ops take 4 cycles each. busy stays high.
- Undefined: FIN always returns to IDLE; run is sampled only in IDLE.

Decomposition:
- Package datapath_ctrl_pkg: op_t enum (OP_ALU=2'b00, OP_MOV=2'b01, OP_ILL2, OP_ILL3); state_t enum; field-offset localparam functions of INSTR_W/SEL_W.
- Sub-module onehot_dec (SEL_W -> NUM_REGS decoder with enable) generates reg_en.

Test Plan:
- Reset mid-op: reset_n low at LOAD_B -> all outputs 0 same cycle. Release, run=1, ALU instr -> full sequence restarts cleanly.
- ALU op rx=3, ry=5, alu_sel=4'hA, mode=1, run pulse at T:
  - T+1 mux_sel=3, en_s=1.
  - T+2 mux_sel=5, en_c=1, alu_sel=A, mode=1.
  - T+3 mux_sel=8, reg_en=8'b0000_1000.
  - T+4 done=1, busy 0 at T+5.
- MOV rx=7, ry=0 -> T+1 mux_sel=0, reg_en=8'h80; T+2 done=1. en_s/en_c never high.
- Illegal op=2'b11 -> T+1 done=1, err=1. reg_en, en_s, en_c stay 0 throughout.
- Instruction changed and run pulsed during LOAD_A -> ignored. Write targets the original rx; one done only.
- NUM_REGS=16, INSTR_W=16, rx=15 -> reg_en=16'h8000, mux_sel=16 in WRITE. With AUTORUN_EN and run held, two ALU ops -> done at T+4 and T+8.
